// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_unit
// Purpose : Control-flow sequencer for fetch redirects (branch, RET/RTI,
//           interrupt) with 16-bit stack push/pop of a 32-bit PC.
//           Optional flags save/restore: define PC_REDIRECT_FLAGS_EN.
// Revision: 1.0  initial release
// ============================================================================
module pc_redirect_unit #(
  parameter int          ACK_TIMEOUT = 15,
  parameter logic [31:0] RESUME_ADJ  = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ret_ex,
  input  logic        rti_ex,
  input  logic        int_req,
  input  logic [31:0] cur_pc,
  output logic        stk_req,
  output logic        stk_we,
  output logic [15:0] stk_wdata,
  input  logic [15:0] stk_rdata,
  input  logic        stk_ack,
`ifdef PC_REDIRECT_FLAGS_EN
  input  logic [3:0]  flags_in,
  output logic [3:0]  flagsRestore,
  output logic        flagsValid,
`endif
  output logic        branchSignal,
  output logic [31:0] jumpAddress,
  output logic        retSignal,
  output logic [31:0] PCFromPop,
  output logic        intSignal,
  output logic        fetchStall,
  output logic        stkErr
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PUSH_HI = 4'd1,
    S_PUSH_LO = 4'd2,
`ifdef PC_REDIRECT_FLAGS_EN
    S_PUSH_FL = 4'd3,
    S_POP_FL  = 4'd5,
`endif
    S_INT_GO  = 4'd4,
    S_POP_LO  = 4'd6,
    S_POP_HI  = 4'd7,
    S_RET_GO  = 4'd8
  } state_t;

  state_t             r_state, w_state_next, w_tgt;
  logic               r_req, w_req_next, w_start;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pend, w_pend_next;
  logic [31:0]        r_resume, w_resume_next;
  logic               w_ack, w_timeout, w_stk_state, w_branch;
  logic               w_load_lo, w_load_hi;
  logic               r_we, w_we_start;
  logic [15:0]        r_wdata, w_wdata_start;
  logic [31:0]        r_pop, r_jump;
  logic               r_branch, r_ret, r_int, r_stall, r_err;
`ifdef PC_REDIRECT_FLAGS_EN
  logic               r_is_rti, w_rti_next, w_load_fl, r_fvalid;
  logic [3:0]         r_flags;
`endif

  // Only an ack that answers a live request counts.
  assign w_ack       = r_req & stk_ack;
  assign w_timeout   = r_req & ~stk_ack & (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign w_stk_state = (r_state != S_IDLE) && (r_state != S_INT_GO) && (r_state != S_RET_GO);

  always_comb begin
    w_state_next  = r_state;
    w_pend_next   = r_pend;
    w_resume_next = r_resume;
    w_branch      = 1'b0;
    w_load_lo     = 1'b0;
    w_load_hi     = 1'b0;
`ifdef PC_REDIRECT_FLAGS_EN
    w_rti_next    = r_is_rti;
    w_load_fl     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (ret_ex || rti_ex) begin
`ifdef PC_REDIRECT_FLAGS_EN
          w_state_next = rti_ex ? S_POP_FL : S_POP_LO;
          w_rti_next   = rti_ex;
`else
          w_state_next = S_POP_LO;
`endif
          if (int_req) w_pend_next = 1'b1;
        end else if (int_req || r_pend) begin
          // A same-cycle taken branch becomes the resume point instead of cur_pc.
          w_state_next  = S_PUSH_HI;
          w_resume_next = branch_taken ? branch_target : (cur_pc + RESUME_ADJ);
          w_pend_next   = 1'b1;
        end else if (branch_taken) begin
          w_branch = 1'b1;
        end
      end
      S_PUSH_HI: if (w_ack) w_state_next = S_PUSH_LO;
`ifdef PC_REDIRECT_FLAGS_EN
      S_PUSH_LO: if (w_ack) w_state_next = S_PUSH_FL;
      S_PUSH_FL: if (w_ack) w_state_next = S_INT_GO;
      S_POP_FL: begin
        if (int_req) w_pend_next = 1'b1;
        if (w_ack) begin
          w_state_next = S_POP_LO;
          w_load_fl    = 1'b1;
        end
      end
`else
      S_PUSH_LO: if (w_ack) w_state_next = S_INT_GO;
`endif
      S_INT_GO: begin
        w_state_next = S_IDLE;
        w_pend_next  = 1'b0;
      end
      S_POP_LO: begin
        if (int_req) w_pend_next = 1'b1;
        if (w_ack) begin
          w_state_next = S_POP_HI;
          w_load_lo    = 1'b1;
        end
      end
      S_POP_HI: begin
        if (int_req) w_pend_next = 1'b1;
        if (w_ack) begin
          w_state_next = S_RET_GO;
          w_load_hi    = 1'b1;
        end
      end
      S_RET_GO: begin
        if (int_req) w_pend_next = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout) w_state_next = S_IDLE;
  end

  // Request sequencing: the first cycle of a follow-on stack state is the
  // mandatory request gap, after which the new transaction starts.
  always_comb begin
    w_req_next = r_req;
    w_start    = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_state_next != S_IDLE) begin
        w_req_next = 1'b1;
        w_start    = 1'b1;
      end
    end else if (w_stk_state) begin
      if (!r_req) begin
        w_req_next = 1'b1;
        w_start    = 1'b1;
      end else if (w_ack || w_timeout) begin
        w_req_next = 1'b0;
      end
    end
  end

  always_comb begin
    w_tgt         = (r_state == S_IDLE) ? w_state_next : r_state;
    w_we_start    = 1'b0;
    w_wdata_start = 16'h0000;
    case (w_tgt)
      S_PUSH_HI: begin
        w_we_start    = 1'b1;
        w_wdata_start = w_resume_next[31:16];
      end
      S_PUSH_LO: begin
        w_we_start    = 1'b1;
        w_wdata_start = w_resume_next[15:0];
      end
`ifdef PC_REDIRECT_FLAGS_EN
      S_PUSH_FL: begin
        w_we_start    = 1'b1;
        w_wdata_start = {12'h000, flags_in};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req    <= 1'b0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_resume <= 32'h0;
      r_we     <= 1'b0;
      r_wdata  <= 16'h0;
      r_pop    <= 32'h0;
      r_jump   <= 32'h0;
      r_branch <= 1'b0;
      r_ret    <= 1'b0;
      r_int    <= 1'b0;
      r_stall  <= 1'b0;
      r_err    <= 1'b0;
`ifdef PC_REDIRECT_FLAGS_EN
      r_is_rti <= 1'b0;
      r_flags  <= 4'h0;
      r_fvalid <= 1'b0;
`endif
    end else begin
      r_req    <= w_req_next;
      r_pend   <= w_pend_next;
      r_resume <= w_resume_next;
      if (w_start) begin
        r_cnt   <= '0;
        r_we    <= w_we_start;
        r_wdata <= w_wdata_start;
      end else if (r_req && !stk_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load_lo) r_pop[15:0]  <= stk_rdata;
      if (w_load_hi) r_pop[31:16] <= stk_rdata;
      r_branch <= w_branch;
      r_jump   <= w_branch ? branch_target : 32'h0;
      r_ret    <= (w_state_next == S_RET_GO);
      r_int    <= (w_state_next == S_INT_GO);
      r_stall  <= (w_state_next != S_IDLE);
      r_err    <= w_timeout;
`ifdef PC_REDIRECT_FLAGS_EN
      r_is_rti <= w_rti_next;
      if (w_load_fl) r_flags <= stk_rdata[3:0];
      r_fvalid <= (w_state_next == S_RET_GO) && r_is_rti;
`endif
    end
  end

  assign stk_req      = r_req;
  assign stk_we       = r_we;
  assign stk_wdata    = r_wdata;
  assign branchSignal = r_branch;
  assign jumpAddress  = r_jump;
  assign retSignal    = r_ret;
  assign PCFromPop    = r_pop;
  assign intSignal    = r_int;
  assign fetchStall   = r_stall;
  assign stkErr       = r_err;
`ifdef PC_REDIRECT_FLAGS_EN
  assign flagsRestore = r_flags;
  assign flagsValid   = r_fvalid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_redirect_unit
// Purpose : Self-checking bench: vector table, stack responder, redirect scoreboard.
// Revision: 1.0  initial release
// ============================================================================
module tb_pc_redirect_unit;

  localparam int K_BR  = 1;
  localparam int K_RET = 2;
  localparam int K_INT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        ret_ex = 1'b0;
  logic        rti_ex = 1'b0;
  logic        int_req = 1'b0;
  logic [31:0] cur_pc = 32'h0;
  logic        stk_req, stk_we;
  logic [15:0] stk_wdata;
  logic [15:0] stk_rdata = 16'h0;
  logic        stk_ack = 1'b0;
  logic        branchSignal, retSignal, intSignal, fetchStall, stkErr;
  logic [31:0] jumpAddress, PCFromPop;
`ifdef PC_REDIRECT_FLAGS_EN
  logic [3:0]  flags_in = 4'b1010;
  logic [3:0]  flagsRestore;
  logic        flagsValid;
`endif

  pc_redirect_unit dut (
    .clk(clk), .reset(reset),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ret_ex(ret_ex), .rti_ex(rti_ex), .int_req(int_req), .cur_pc(cur_pc),
    .stk_req(stk_req), .stk_we(stk_we), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_ack(stk_ack),
`ifdef PC_REDIRECT_FLAGS_EN
    .flags_in(flags_in), .flagsRestore(flagsRestore), .flagsValid(flagsValid),
`endif
    .branchSignal(branchSignal), .jumpAddress(jumpAddress),
    .retSignal(retSignal), .PCFromPop(PCFromPop),
    .intSignal(intSignal), .fetchStall(fetchStall), .stkErr(stkErr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  typedef struct {
    int          kind;
    logic [31:0] addr;
  } ev_t;

  logic [15:0] exp_push_q[$];
  logic [15:0] pop_q[$];
  ev_t         exp_ev_q[$];

  // Stack responder: acks ack_dly cycles after a request, checks pushed words.
  int ack_dly = 2;
  bit ack_off = 1'b0;
  int wcnt    = 0;
  always @(negedge clk) begin
    if (stk_ack) begin
      stk_ack = 1'b0;
    end else if (stk_req && !ack_off && !reset) begin
      if (wcnt >= ack_dly - 1) begin
        stk_ack = 1'b1;
        wcnt    = 0;
        if (stk_we) begin
          if (exp_push_q.size() == 0) fail_now("push_unexpected");
          else check("push_word", 32'(stk_wdata), 32'(exp_push_q.pop_front()));
        end else begin
          stk_rdata = (pop_q.size() > 0) ? pop_q.pop_front() : 16'hDEAD;
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Redirect monitor / scoreboard.
  int  err_cnt = 0;
  ev_t mon_ev;
  int  mon_kind;
  always @(negedge clk) begin
    if (!reset) begin
      if (stkErr) err_cnt++;
      if (branchSignal || retSignal || intSignal) begin
        check("pulse_onehot", 32'(branchSignal) + 32'(retSignal) + 32'(intSignal), 32'd1);
        mon_kind = branchSignal ? K_BR : (retSignal ? K_RET : K_INT);
        if (exp_ev_q.size() == 0) begin
          fail_now("unexpected_redirect");
        end else begin
          mon_ev = exp_ev_q.pop_front();
          check("redirect_kind", 32'(mon_kind), 32'(mon_ev.kind));
          if (mon_kind == K_BR) begin
            check("jumpAddress", jumpAddress, mon_ev.addr);
            check("stall_on_branch", 32'(fetchStall), 32'd0);
          end else if (mon_kind == K_RET) begin
            check("PCFromPop", PCFromPop, mon_ev.addr);
            check("stall_on_ret", 32'(fetchStall), 32'd1);
          end else begin
            check("stall_on_int", 32'(fetchStall), 32'd1);
          end
        end
      end
    end
  end

  task automatic expect_pushes(input logic [15:0] w0, input logic [15:0] w1);
    exp_push_q.push_back(w0);
    exp_push_q.push_back(w1);
`ifdef PC_REDIRECT_FLAGS_EN
    exp_push_q.push_back(16'h000A);
`endif
  endtask

  task automatic wait_idle(input int lim);
    int c = 0;
    repeat (3) @(negedge clk);
    while ((fetchStall || exp_ev_q.size() != 0) && c < lim) begin
      c++;
      @(negedge clk);
    end
    if (c >= lim) fail_now("wait_idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic        irq, br, ret, rti;
    logic [31:0] tgt, pc;
    logic [15:0] p0, p1;
    int          ekind;
    logic [31:0] eaddr;
    int          npush;
    logic [15:0] w0, w1;
  } vec_t;

  vec_t vt[8];
  int   cnt;
  bit   saw_req;

  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 16'h0, 16'h0, K_BR, 32'h0000_0040, 0, 16'h0, 16'h0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_1234, 16'h0, 16'h0, K_INT, 32'h0, 2, 16'h0000, 16'h1234};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 16'h5678, 16'h0001, K_RET, 32'h0001_5678, 0, 16'h0, 16'h0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_1234, 16'h0, 16'h0, K_INT, 32'h0, 2, 16'h0000, 16'h0080};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEC, 32'h0000_1234, 16'h0, 16'h0, K_BR, 32'hDEAD_BEEC, 0, 16'h0, 16'h0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFE_0010, 16'h0, 16'h0, K_INT, 32'h0, 2, 16'hCAFE, 16'h0010};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 16'hAAAA, 16'h5555, K_RET, 32'h5555_AAAA, 0, 16'h0, 16'h0};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 16'h0F0F, 16'hF0F0, K_RET, 32'hF0F0_0F0F, 0, 16'h0, 16'h0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_stk_req", 32'(stk_req), 0);
    check("rst_stk_we", 32'(stk_we), 0);
    check("rst_stk_wdata", 32'(stk_wdata), 0);
    check("rst_branchSignal", 32'(branchSignal), 0);
    check("rst_jumpAddress", jumpAddress, 0);
    check("rst_retSignal", 32'(retSignal), 0);
    check("rst_PCFromPop", PCFromPop, 0);
    check("rst_intSignal", 32'(intSignal), 0);
    check("rst_fetchStall", 32'(fetchStall), 0);
    check("rst_stkErr", 32'(stkErr), 0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef PC_REDIRECT_FLAGS_EN
      if (vt[i].rti) pop_q.push_back(16'h000A);
`endif
      if (vt[i].ret || vt[i].rti) begin
        pop_q.push_back(vt[i].p0);
        pop_q.push_back(vt[i].p1);
      end
      if (vt[i].npush == 2) expect_pushes(vt[i].w0, vt[i].w1);
      exp_ev_q.push_back('{vt[i].ekind, vt[i].eaddr});
      int_req       = vt[i].irq;
      branch_taken  = vt[i].br;
      branch_target = vt[i].tgt;
      ret_ex        = vt[i].ret;
      rti_ex        = vt[i].rti;
      cur_pc        = vt[i].pc;
      @(negedge clk);
      int_req = 1'b0; branch_taken = 1'b0; ret_ex = 1'b0; rti_ex = 1'b0;
      check("accept_branch", 32'(branchSignal), 32'(vt[i].ekind == K_BR));
      check("accept_stall", 32'(fetchStall), 32'(vt[i].ekind != K_BR));
      wait_idle(200);
      check("ev_drained", 32'(exp_ev_q.size()), 0);
      check("push_drained", 32'(exp_push_q.size()), 0);
    end

    // RET and interrupt together: return completes, then the interrupt runs.
    @(negedge clk);
    pop_q.push_back(16'h2222);
    pop_q.push_back(16'h0003);
    expect_pushes(16'h0000, 16'h9000);
    exp_ev_q.push_back('{K_RET, 32'h0003_2222});
    exp_ev_q.push_back('{K_INT, 32'h0});
    cur_pc = 32'h0000_9000; int_req = 1'b1; ret_ex = 1'b1;
    @(negedge clk);
    int_req = 1'b0; ret_ex = 1'b0;
    wait_idle(200);
    check("intret_ev_drained", 32'(exp_ev_q.size()), 0);
    check("intret_push_drained", 32'(exp_push_q.size()), 0);

    // Ack timeout followed by an automatic retry of the interrupt.
    ack_off = 1'b1;
    err_cnt = 0;
    expect_pushes(16'h0000, 16'h4444);
    exp_ev_q.push_back('{K_INT, 32'h0});
    cur_pc = 32'h0000_4444; int_req = 1'b1;
    @(negedge clk);
    int_req = 1'b0;
    cnt = 0;
    while (stk_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(cnt), 32'd15);
    check("timeout_stkErr", 32'(stkErr), 32'd1);
    check("timeout_stall", 32'(fetchStall), 32'd0);
    ack_off = 1'b0;
    wait_idle(200);
    check("timeout_err_count", 32'(err_cnt), 32'd1);
    check("retry_ev_drained", 32'(exp_ev_q.size()), 0);
    check("retry_push_drained", 32'(exp_push_q.size()), 0);

    // Reset in the middle of the low-word push.
    ack_dly = 4;
    exp_push_q.push_back(16'h0000);
    cur_pc = 32'h0000_7777; int_req = 1'b1;
    @(negedge clk);
    int_req = 1'b0;
    cnt = 0;
    while (!(stk_req && stk_we && stk_wdata == 16'h7777) && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 50) fail_now("push_lo_not_reached");
    reset = 1'b1;
    @(negedge clk);
    check("midrst_stk_req", 32'(stk_req), 0);
    check("midrst_stk_we", 32'(stk_we), 0);
    check("midrst_stk_wdata", 32'(stk_wdata), 0);
    check("midrst_fetchStall", 32'(fetchStall), 0);
    check("midrst_PCFromPop", PCFromPop, 0);
    check("midrst_intSignal", 32'(intSignal), 0);
    reset = 1'b0;
    exp_push_q.delete();
    exp_ev_q.delete();
    saw_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (stk_req || fetchStall) saw_req = 1'b1;
    end
    check("midrst_pending_cleared", 32'(saw_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
